// File: rtl/regfile_mp_sb_pkg.sv
// rtl/regfile_mp_sb_pkg.sv - shared register-file constants and ABI register indices
package regfile_mp_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // ABI register indices, shared with decode.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;
    localparam int REG_TP   = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy scoreboard with issue set and writeback clear
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   iss_en, iss_addr      mark destination register busy
//   clr_en, wr_en,        per-write-port busy clear; wr_en/wr_addr also
//   wr_addr               qualify the same-cycle bypass that hides busy
//   rd_addr               packed read-port addresses
//   rd_busy               per-read-port pending-source flag
//   stall                 any nonzero-address read port busy
module rf_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [NWRITE-1:0]   clr_en,
    input  logic [NWRITE-1:0]   wr_en,
    input  logic [NWRITE*AW-1:0] wr_addr,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD-1:0]    rd_busy,
    output logic                stall
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Clears are applied first so a same-cycle issue to the same register
    // wins: the new producer is still outstanding.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWRITE; k++) begin
            if (clr_en[k]) busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
        end
        if (iss_en) busy_nxt[iss_addr] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // A writeback landing this cycle that also clears busy supplies the value
    // through the bypass, so the reader need not wait.
    for (genvar p = 0; p < NREAD; p++) begin : g_rd_busy
        logic [AW-1:0] a;
        logic          byp_clr;
        assign a = rd_addr[p*AW +: AW];
        always_comb begin
            byp_clr = 1'b0;
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en[k] && clr_en[k] && wr_addr[k*AW +: AW] == a) byp_clr = 1'b1;
            end
        end
        assign rd_busy[p] = busy[a] & ~byp_clr;
    end

    always_comb begin
        stall = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (rd_busy[p] && rd_addr[p*AW +: AW] != AW'(REG_ZERO)) stall = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write priority, read bypass and scoreboard
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rd_addr / rd_data     packed combinational read ports (port p at p*AW / p*XLEN)
//   rd_busy, stall        scoreboard status of read sources
//   wr_en/wr_addr/wr_data packed write ports, highest index wins
//   iss_en, iss_addr      issue marks destination busy
//   clr_en                per-write-port busy clear
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic [NWRITE-1:0]     wr_en,
    input  logic [NWRITE*AW-1:0]  wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic [NWRITE-1:0]     clr_en,
    output logic                  stall
);

    logic [XLEN-1:0] regs [NREGS];

    // Ports are scanned in ascending order, so the last matching
    // non-blocking assignment (highest index) takes effect. x0 is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                for (int k = 0; k < NWRITE; k++) begin
                    if (wr_en[k] && wr_addr[k*AW +: AW] == AW'(r))
                        regs[r] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        assign a = rd_addr[p*AW +: AW];
        always_comb begin
            d = regs[a];
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en[k] && wr_addr[k*AW +: AW] == a) d = wr_data[k*XLEN +: XLEN];
            end
            if (a == AW'(REG_ZERO)) d = '0;
        end
        assign rd_data[p*XLEN +: XLEN] = d;
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (clr_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .stall    (stall)
    );

endmodule
